// File: rtl/rgmii_rx_frame.sv
// RGMII receive front end: assembles bytes (DDR or nibble), strips preamble/SFD and
// frames the stream with start/end markers, length and error flags, plus in-band status.
module rgmii_rx_frame #(
  parameter int unsigned LEN_W          = 12,
  parameter int unsigned MAX_LEN        = 1518,
  parameter int unsigned MIN_LEN        = 64,
  parameter bit          STRIP_PREAMBLE = 1'b1
) (
  input  logic             gmii_rx_clk,
  input  logic             rst,
  input  logic             speed_1g,
  input  logic [3:0]       rxd_h,
  input  logic [3:0]       rxd_l,
  input  logic             ctl_h,
  input  logic             ctl_l,
  output logic             gmii_rx_dv,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_er,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic [LEN_W-1:0] rx_frame_len,
  output logic             rx_err,
  output logic             rx_oversize,
  output logic             rx_runt,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_duplex
);

  typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

  localparam logic [LEN_W-1:0] LenSat = '1;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_LEN);

  // Stage 0: register the DDR halves and decode RX_DV / RX_ER.
  logic       dv_q, er_q;
  logic [3:0] rxd_h_q, rxd_l_q;

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      rxd_h_q <= 4'h0;
      rxd_l_q <= 4'h0;
    end else begin
      dv_q    <= ctl_h;
      er_q    <= ctl_h ^ ctl_l;
      rxd_h_q <= rxd_h;
      rxd_l_q <= rxd_l;
    end
  end

  // Byte assembly; in nibble mode the low nibble arrives first.
  logic       phase_q, phase_d;
  logic [3:0] lo_q, lo_d;
  logic       er_lo_q, er_lo_d;
  logic       byte_vld, byte_er, odd_end;
  logic [7:0] byte_dat;

  always_comb begin
    phase_d  = phase_q;
    lo_d     = lo_q;
    er_lo_d  = er_lo_q;
    byte_vld = 1'b0;
    byte_dat = {rxd_l_q, rxd_h_q};
    byte_er  = er_q;
    odd_end  = 1'b0;
    if (speed_1g) begin
      byte_vld = dv_q;
      phase_d  = 1'b0;
    end else if (!dv_q) begin
      odd_end = phase_q;
      phase_d = 1'b0;
    end else if (!phase_q) begin
      lo_d    = rxd_h_q;
      er_lo_d = er_q;
      phase_d = 1'b1;
    end else begin
      byte_vld = 1'b1;
      byte_dat = {rxd_h_q, lo_q};
      byte_er  = er_q | er_lo_q;
      phase_d  = 1'b0;
    end
  end

  // Framing FSM.
  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             sof_pend_q, sof_pend_d;
  logic             fwd, eof_d, frame_err_d;
  logic [LEN_W-1:0] len_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    sof_pend_d  = sof_pend_q;
    fwd         = 1'b0;
    eof_d       = 1'b0;
    frame_err_d = 1'b0;
    len_d       = '0;
    unique case (state_q)
      StIdle, StPre: begin
        if (state_q == StIdle) begin
          err_d      = 1'b0;
          sof_pend_d = 1'b1;
        end
        if (!dv_q) begin
          state_d = StIdle;
        end else if (er_q) begin
          state_d = StDrop;
          err_d   = 1'b1;
        end else if (byte_vld) begin
          if (byte_dat == 8'hD5) begin
            state_d = StData;
            cnt_d   = '0;
            fwd     = !STRIP_PREAMBLE;
          end else if (byte_dat == 8'h55) begin
            state_d = StPre;
            fwd     = !STRIP_PREAMBLE;
          end else begin
            state_d = StDrop;
            err_d   = 1'b1;
          end
        end else begin
          state_d = StPre;
        end
      end
      StData: begin
        if (!dv_q) begin
          state_d     = StIdle;
          eof_d       = 1'b1;
          len_d       = cnt_q;
          frame_err_d = err_q | odd_end;
        end else if (byte_vld) begin
          fwd = 1'b1;
          if (byte_er) err_d = 1'b1;
          if (cnt_q != LenSat) cnt_d = cnt_q + LEN_W'(1);
        end
      end
      StDrop: begin
        if (!dv_q) begin
          state_d     = StIdle;
          eof_d       = 1'b1;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fwd) sof_pend_d = 1'b0;
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      phase_q      <= 1'b0;
      lo_q         <= 4'h0;
      er_lo_q      <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      sof_pend_q   <= 1'b0;
      gmii_rx_dv   <= 1'b0;
      gmii_rxd     <= 8'h00;
      gmii_rx_er   <= 1'b0;
      rx_sof       <= 1'b0;
      rx_eof       <= 1'b0;
      rx_frame_len <= '0;
      rx_err       <= 1'b0;
      rx_oversize  <= 1'b0;
      rx_runt      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      er_lo_q    <= er_lo_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      sof_pend_q <= sof_pend_d;
      gmii_rx_dv <= fwd;
      gmii_rxd   <= fwd ? byte_dat : 8'h00;
      gmii_rx_er <= fwd & byte_er;
      rx_sof     <= fwd & sof_pend_q;
      rx_eof     <= eof_d;
      if (eof_d) begin
        rx_frame_len <= len_d;
        rx_err       <= frame_err_d;
        rx_oversize  <= len_d > MaxLen;
        rx_runt      <= len_d < MinLen;
      end
    end
  end

  // In-band status: idle, error-free samples; two matching samples in a row commit.
  logic [3:0] stat_q;
  logic       stat_vld_q;

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      stat_q      <= 4'h0;
      stat_vld_q  <= 1'b0;
      link_up     <= 1'b0;
      link_speed  <= 2'b00;
      link_duplex <= 1'b0;
    end else if (!dv_q && !er_q) begin
      stat_q     <= rxd_h_q;
      stat_vld_q <= 1'b1;
      if (stat_vld_q && (stat_q == rxd_h_q)) begin
        link_up     <= rxd_h_q[0];
        link_speed  <= rxd_h_q[2:1];
        link_duplex <= rxd_h_q[3];
      end
    end else if (dv_q) begin
      stat_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Scoreboard bench for rgmii_rx_frame: expected bytes and frame ends are queued as
// stimulus is driven and compared, including arrival cycle, as the DUT emits them.
module tb_rgmii_rx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        speed_1g = 1'b1;
  logic [3:0]  rxd_h = 4'h0, rxd_l = 4'h0;
  logic        ctl_h = 1'b0, ctl_l = 1'b0;
  logic        gmii_rx_dv, gmii_rx_er, rx_sof, rx_eof;
  logic [7:0]  gmii_rxd;
  logic [11:0] rx_frame_len;
  logic        rx_err, rx_oversize, rx_runt, link_up, link_duplex;
  logic [1:0]  link_speed;

  rgmii_rx_frame dut (
    .gmii_rx_clk (clk),
    .rst         (rst),
    .speed_1g    (speed_1g),
    .rxd_h       (rxd_h),
    .rxd_l       (rxd_l),
    .ctl_h       (ctl_h),
    .ctl_l       (ctl_l),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .gmii_rx_er  (gmii_rx_er),
    .rx_sof      (rx_sof),
    .rx_eof      (rx_eof),
    .rx_frame_len(rx_frame_len),
    .rx_err      (rx_err),
    .rx_oversize (rx_oversize),
    .rx_runt     (rx_runt),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .link_duplex (link_duplex)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  dat;
    logic        er;
    logic        sof;
  } bexp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [11:0] len;
    logic        err;
    logic        over;
    logic        runt;
  } eexp_t;

  bexp_t bq[$];
  eexp_t eq[$];
  bexp_t bcur;
  eexp_t ecur;

  always @(negedge clk) begin
    if (gmii_rx_dv) begin
      if (bq.size() == 0) begin
        check_eq("unexpected_byte", 32'(gmii_rx_dv), 32'd0);
      end else begin
        bcur = bq.pop_front();
        check_eq("byte_cycle", cyc, bcur.cyc);
        check_eq("byte_data", 32'(gmii_rxd), 32'(bcur.dat));
        check_eq("byte_er", 32'(gmii_rx_er), 32'(bcur.er));
        check_eq("byte_sof", 32'(rx_sof), 32'(bcur.sof));
      end
    end else if (rx_sof || gmii_rx_er) begin
      check_eq("stray_sof_er", 32'({rx_sof, gmii_rx_er}), 32'd0);
    end
    if (rx_eof) begin
      if (eq.size() == 0) begin
        check_eq("unexpected_eof", 32'(rx_eof), 32'd0);
      end else begin
        ecur = eq.pop_front();
        check_eq("eof_cycle", cyc, ecur.cyc);
        check_eq("eof_len", 32'(rx_frame_len), 32'(ecur.len));
        check_eq("eof_err", 32'(rx_err), 32'(ecur.err));
        check_eq("eof_oversize", 32'(rx_oversize), 32'(ecur.over));
        check_eq("eof_runt", 32'(rx_runt), 32'(ecur.runt));
      end
    end
  end

  logic [3:0] idle_nib = 4'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit dv, input bit er, input logic [3:0] h, input logic [3:0] l);
    tick();
    ctl_h = dv;
    ctl_l = dv ^ er;
    rxd_h = h;
    rxd_l = l;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b0, 1'b0, idle_nib, 4'h0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit er, input bit exp_out, input bit sof);
    if (speed_1g) begin
      put(1'b1, er, b[3:0], b[7:4]);
    end else begin
      put(1'b1, er, b[3:0], 4'h0);
      put(1'b1, er, b[7:4], 4'h0);
    end
    if (exp_out) bq.push_back('{cyc + 2, b, er, sof});
  endtask

  // bad_pre != 0 replaces the 4th preamble byte, so the frame must be dropped.
  task automatic send_frame(input int n, input int err_idx, input bit odd_tail,
                            input logic [7:0] bad_pre, input int gap);
    bit good;
    bit ferr;
    good = (bad_pre == 8'h00);
    ferr = odd_tail;
    for (int p = 0; p < 7; p++) send_byte((!good && p == 3) ? bad_pre : 8'h55, 1'b0, 1'b0, 1'b0);
    send_byte(8'hD5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      send_byte(8'(i), i == err_idx, good, i == 0);
      if (i == err_idx) ferr = 1'b1;
    end
    if (odd_tail) put(1'b1, 1'b0, 4'h3, 4'h0);
    put(1'b0, 1'b0, idle_nib, 4'h0);
    if (good) eq.push_back('{cyc + 2, 12'(n), ferr, n > 1518, n < 64});
    else      eq.push_back('{cyc + 2, 12'd0, 1'b1, 1'b0, 1'b1});
    idle(gap - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bytes pending %0d", bq.size());
    $fatal(1);
  end

  initial begin
    idle(3);
    check_eq("reset_outputs",
             {1'b0, gmii_rx_dv, gmii_rxd, gmii_rx_er, rx_sof, rx_eof, rx_frame_len, rx_err,
              rx_oversize, rx_runt, link_up, link_speed, link_duplex}, 32'd0);
    tick();
    rst = 1'b0;
    idle(4);

    // In-band status: single sample must not commit, two matching samples must.
    put(1'b0, 1'b0, 4'b1101, 4'h0);
    put(1'b0, 1'b0, 4'b0000, 4'h0);
    put(1'b0, 1'b0, 4'b0000, 4'h0);
    check_eq("link_single_sample", 32'(link_up), 32'd0);
    idle_nib = 4'b1101;
    idle(2);
    for (int k = 0; k < 3; k++) put(1'b0, 1'b1, 4'b0000, 4'h0);
    check_eq("link_up", 32'(link_up), 32'd1);
    check_eq("link_speed", 32'(link_speed), 32'd2);
    check_eq("link_duplex", 32'(link_duplex), 32'd1);
    idle(3);
    put(1'b0, 1'b0, 4'b0000, 4'h0);
    put(1'b0, 1'b0, idle_nib, 4'h0);
    put(1'b0, 1'b0, idle_nib, 4'h0);
    check_eq("link_glitch_up", 32'(link_up), 32'd1);
    check_eq("link_glitch_duplex", 32'(link_duplex), 32'd1);
    for (int k = 0; k < 5; k++) put(1'b0, 1'b1, 4'b0000, 4'h0);
    check_eq("link_false_carrier", 32'(link_up), 32'd1);
    idle(4);

    // 1000M frames: clean, byte error, bad preamble, runt back-to-back with oversize.
    send_frame(100, -1, 1'b0, 8'h00, 8);
    send_frame(100, 40, 1'b0, 8'h00, 8);
    send_frame(10, -1, 1'b0, 8'h57, 8);
    send_frame(40, -1, 1'b0, 8'h00, 1);
    send_frame(1600, -1, 1'b0, 8'h00, 8);
    check_eq("link_after_frames", 32'(link_up), 32'd1);

    // 10/100 nibble mode.
    speed_1g = 1'b0;
    idle(4);
    send_frame(100, -1, 1'b0, 8'h00, 8);
    send_frame(20, -1, 1'b1, 8'h00, 8);
    send_frame(70, 5, 1'b0, 8'h00, 8);
    speed_1g = 1'b1;
    idle(4);

    // Reset at byte 50; byte 49 is still in flight and is lost.
    for (int p = 0; p < 7; p++) send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    send_byte(8'hD5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) send_byte(8'(i), 1'b0, i < 49, i == 0);
    put(1'b1, 1'b0, 4'h2, 4'h3);
    rst = 1'b1;
    tick();
    check_eq("midframe_reset_outputs",
             {1'b0, gmii_rx_dv, gmii_rxd, gmii_rx_er, rx_sof, rx_eof, rx_frame_len, rx_err,
              rx_oversize, rx_runt, link_up, link_speed, link_duplex}, 32'd0);
    rst = 1'b0;
    for (int i = 51; i < 80; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b0);
    put(1'b0, 1'b0, idle_nib, 4'h0);
    eq.push_back('{cyc + 2, 12'd0, 1'b1, 1'b0, 1'b1});
    idle(8);
    send_frame(80, -1, 1'b0, 8'h00, 10);

    check_eq("bytes_pending", 32'(bq.size()), 32'd0);
    check_eq("eofs_pending", 32'(eq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_frame.md
# rgmii_rx_frame

Receive-side frame front end for the RGMII path, running entirely in the recovered receive clock domain. It takes the two per-cycle halves already captured by the DDR input cells, assembles bytes for 1000M (DDR) or 10/100M (nibble) operation, and decodes RGMII receive errors and in-band link status. It strips preamble/SFD and emits a framed byte stream with start/end markers, length and error flags to the downstream UDP/image receive logic.

## Interface
- LEN_W, 12: width of frame byte counter and rx_frame_len
- MAX_LEN, 1518: frames with more payload bytes than this flag rx_oversize
- MIN_LEN, 64: frames with fewer payload bytes than this flag rx_runt
- STRIP_PREAMBLE, 1: 1 = preamble and SFD not forwarded; 0 = forwarded, with gmii_rx_dv high
- gmii_rx_clk  in  1  receive clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- speed_1g  in  1  1 = DDR byte mode; 0 = 10/100 nibble mode; quasi-static, change only while link idle
- rxd_h  in  4  nibble captured on rising edge
- rxd_l  in  4  nibble captured on falling edge
- ctl_h  in  1  RX_CTL captured on rising edge (RX_DV)
- ctl_l  in  1  RX_CTL captured on falling edge (RX_DV xor RX_ER)
- gmii_rx_dv  out  1  output byte strobe
- gmii_rxd  out  8  output byte
- gmii_rx_er  out  1  receive error on this byte
- rx_sof  out  1  high with first forwarded byte
- rx_eof  out  1  single-cycle pulse, 1 cycle after last byte
- rx_frame_len  out  LEN_W  payload bytes after SFD, held until next rx_eof
- rx_err  out  1  frame saw rx_er or bad preamble, held with rx_frame_len
- rx_oversize  out  1  held with rx_frame_len
- rx_runt  out  1  held with rx_frame_len
- link_up  out  1  in-band link status
- link_speed  out  2  in-band speed: 00 = 10M, 01 = 100M, 10 = 1000M
- link_duplex  out  1  in-band duplex, 1 = full

## Operation
- Stage 0 registers the inputs: dv = ctl_h, er = ctl_h ^ ctl_l.
- 1000M mode: each cycle with dv=1 forms byte {rxd_l, rxd_h}.
- 10/100 mode: only rxd_h is used. The first nibble after dv rises is bits [3:0]; the next nibble is bits [7:4]. One byte is formed every 2 cycles, and er is ORed over both nibble cycles.
- If dv falls on an odd nibble, the half byte is discarded and rx_err is set.
- FSM states: IDLE, PRE, DATA, DROP.
  - IDLE: on dv=1 go to PRE.
  - PRE: byte 0x55 stays in PRE; byte 0xD5 goes to DATA; any other byte, or er, goes to DROP with rx_err=1. dv=0 returns to IDLE with no rx_eof.
  - DATA: each byte is forwarded and counted. er on a byte sets gmii_rx_er and the sticky frame error. dv=0 pulses rx_eof, latches the length and flags, then goes to IDLE.
  - DROP: nothing is forwarded. dv=0 pulses rx_eof with rx_err=1 and length 0, then goes to IDLE.
- STRIP_PREAMBLE=0: preamble and SFD bytes are also output, and rx_sof is on the first preamble byte. The counted length still excludes them.
- Counter saturates at 2^LEN_W-1.
- rx_oversize = len > MAX_LEN. rx_runt = len < MIN_LEN.
- In-band status: sampled only when dv=0 and er=0, from rxd_h: bit0 = link, bits[2:1] = speed, bit3 = duplex. The outputs update only after two consecutive identical samples.
- Carrier/false-carrier patterns with dv=0 and er=1 are ignored: no status update and no frame.

## Timing
- Reset values: all outputs 0, counter 0, FSM in IDLE, nibble phase even.
- Latency, 1000M: a byte presented on rxd_h/rxd_l at cycle N appears on gmii_rxd at N+2.
- Latency, 10/100: the byte appears 2 cycles after its high nibble cycle.
- gmii_rx_dv high for one cycle per byte:
  - 1000M: back-to-back every cycle.
  - 10/100: every other cycle.
- rx_eof occurs in the cycle after the last gmii_rx_dv. rx_frame_len, rx_err, rx_oversize and rx_runt are valid from that cycle and stable until the next rx_eof.
- If dv rises in the same cycle rx_eof is generated, the new frame is accepted normally; no idle gap is required.
- Reset asserted mid-frame: outputs are 0 the next cycle and no rx_eof is issued. After release, the first frame starts cleanly; a frame already in progress is seen as lacking SFD and is handled in PRE/DROP.
- Status outputs change only in IDLE periods.

## Test plan
- 1000M frame with 7×0x55, 0xD5, then 100 bytes 0x00..0x63, no errors -> 100 strobes, data 0x00..0x63 at +2 latency, rx_sof on 0x00, rx_eof with len=100 and all flags 0.
- 10/100 mode, same frame as nibbles, low nibble first -> identical byte sequence with strobes every 2 cycles and len=100; then a frame ending on an odd nibble -> rx_err=1.
- Byte 40 with ctl_l=0 while ctl_h=1 -> gmii_rx_er=1 on byte 40 only; rx_err=1 at eof and len unchanged.
- Preamble byte 0x57 -> nothing forwarded and rx_eof with rx_err=1, len=0. Frames of 40 bytes and 1600 bytes -> rx_runt=1 and rx_oversize=1 respectively.
- Idle with rxd_h=4'b1101 for 2 cycles -> link_up=1, link_speed=10, link_duplex=1. A single-cycle glitch of 4'b0000 -> no change.
- rst pulsed at byte 50 -> all outputs 0 the next cycle, no rx_eof. A following clean frame -> correct len.
